// File: rtl/cnn_pkg.sv
// Shared types and frame-geometry helpers for the 3x3 window generator.
// CNN_WIN_PAD_EN selects the zero-padded grid (extended dimension = image + 2).
package cnn_pkg;

  localparam int WIDTH = 8;

  typedef logic signed [WIDTH:0] pixel_t;

  typedef enum logic [1:0] {FILL, RUN, WRAP} win_state_e;

`ifdef CNN_WIN_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  function automatic int ext_dim(input int img);
    return PAD_EN ? img + 2 : img;
  endfunction

endpackage

// File: rtl/cnn_line_buffer.sv
// Row delay line: dout is the sample shifted in DEPTH enabled steps earlier.
// Holds its contents while shift_en is low; contents are never cleared.
module cnn_line_buffer
  import cnn_pkg::*;
#(
  parameter int WIDTH = cnn_pkg::WIDTH,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              shift_en,
  input  logic signed [WIDTH:0] din,
  output logic signed [WIDTH:0] dout
);

  logic signed [WIDTH:0] mem_q [DEPTH];
  logic signed [WIDTH:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (shift_en) begin
      mem_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_d[i] = mem_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/cnn_window_gen.sv
// Raster pixel stream to registered 3x3 windows, one per step; a window stall freezes taps and drops in_ready.
// CNN_WIN_PAD_EN enables zero-padded full-size output; otherwise only interior windows are produced.
module cnn_window_gen
  import cnn_pkg::*;
#(
  parameter int WIDTH = cnn_pkg::WIDTH,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [WIDTH:0]    in_data,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic signed [WIDTH:0]    W1, W2, W3, W4, W5, W6, W7, W8, W9,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col,
  output logic                     win_last
);

  localparam int EXT_W   = ext_dim(IMG_W);
  localparam int EXT_H   = ext_dim(IMG_H);
  localparam int CW      = $clog2(EXT_W);
  localparam int RW      = $clog2(EXT_H);
  localparam int OR_W    = $clog2(IMG_H);
  localparam int OC_W    = $clog2(IMG_W);
  localparam int CTR_OFF = PAD_EN ? 2 : 1;
  localparam logic [CW-1:0] EC_LAST = CW'(EXT_W - 1);
  localparam logic [RW-1:0] ER_LAST = RW'(EXT_H - 1);

  logic [RW-1:0]   er_q, er_d;
  logic [CW-1:0]   ec_q, ec_d;
  win_state_e      state_q, state_d;
  logic            win_valid_q, win_valid_d;
  logic            win_last_q, win_last_d;
  logic [OR_W-1:0] win_row_q, win_row_d;
  logic [OC_W-1:0] win_col_q, win_col_d;
  logic signed [WIDTH:0] arr_q [3][3];
  logic signed [WIDTH:0] arr_d [3][3];

  logic pos_real, step_ok, step, emit;
  logic signed [WIDTH:0] sample, lb1_out, lb2_out;

  // Border positions of the padded grid are virtual: they step without input and inject zero.
`ifdef CNN_WIN_PAD_EN
  assign pos_real = (er_q != '0) && (er_q != ER_LAST) && (ec_q != '0) && (ec_q != EC_LAST);
`else
  assign pos_real = 1'b1;
`endif

  assign step_ok  = !win_valid_q || win_ready;
  assign step     = step_ok && (in_valid || !pos_real);
  assign in_ready = !rst && step_ok && pos_real;
  assign sample   = pos_real ? in_data : '0;
  // FILL gating keeps stale line-buffer rows from a previous frame out of any window.
  assign emit     = step && (state_q != FILL) && (ec_q >= CW'(2));

  cnn_line_buffer #(.WIDTH(WIDTH), .DEPTH(EXT_W)) u_lb1 (
    .clk(clk), .shift_en(step), .din(sample), .dout(lb1_out)
  );

  cnn_line_buffer #(.WIDTH(WIDTH), .DEPTH(EXT_W)) u_lb2 (
    .clk(clk), .shift_en(step), .din(lb1_out), .dout(lb2_out)
  );

  always_comb begin
    er_d        = er_q;
    ec_d        = ec_q;
    state_d     = state_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    arr_d       = arr_q;
    if (step) begin
      if (state_q == WRAP) begin
        er_d = '0;
        ec_d = '0;
      end else if (ec_q == EC_LAST) begin
        ec_d = '0;
        er_d = er_q + RW'(1);
      end else begin
        ec_d = ec_q + CW'(1);
      end
      if ((er_d == ER_LAST) && (ec_d == EC_LAST)) state_d = WRAP;
      else if (er_d < RW'(2))                      state_d = FILL;
      else                                         state_d = RUN;

      for (int r = 0; r < 3; r++) begin
        arr_d[r][0] = arr_q[r][1];
        arr_d[r][1] = arr_q[r][2];
      end
      arr_d[0][2] = lb2_out;
      arr_d[1][2] = lb1_out;
      arr_d[2][2] = sample;

      win_valid_d = emit;
      win_last_d  = emit && (state_q == WRAP);
      if (emit) begin
        win_row_d = OR_W'(er_q - RW'(CTR_OFF));
        win_col_d = OC_W'(ec_q - CW'(CTR_OFF));
      end
    end else if (win_ready) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      er_q        <= '0;
      ec_q        <= '0;
      state_q     <= FILL;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      arr_q       <= '{default: '0};
    end else begin
      er_q        <= er_d;
      ec_q        <= ec_d;
      state_q     <= state_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      arr_q       <= arr_d;
    end
  end

  assign win_valid = win_valid_q;
  assign win_last  = win_last_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;
  assign W1 = arr_q[0][0];
  assign W2 = arr_q[0][1];
  assign W3 = arr_q[0][2];
  assign W4 = arr_q[1][0];
  assign W5 = arr_q[1][1];
  assign W6 = arr_q[1][2];
  assign W7 = arr_q[2][0];
  assign W8 = arr_q[2][1];
  assign W9 = arr_q[2][2];

endmodule

// File: tb/tb_cnn_window_gen.sv
// Scoreboard bench for cnn_window_gen on a 4x4 image with p(r,c) = 4r+c.
module tb_cnn_window_gen;

  localparam int N = 4;
`ifdef CNN_WIN_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [8:0] in_data = '0;
  logic win_valid;
  logic win_ready = 1'b1;
  logic signed [8:0] w [9];
  logic [1:0] win_row, win_col;
  logic win_last;

  cnn_window_gen #(.WIDTH(8), .IMG_W(N), .IMG_H(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .win_valid(win_valid), .win_ready(win_ready),
    .W1(w[0]), .W2(w[1]), .W3(w[2]), .W4(w[3]), .W5(w[4]),
    .W6(w[5]), .W7(w[6]), .W8(w[7]), .W9(w[8]),
    .win_row(win_row), .win_col(win_col), .win_last(win_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int t[9];
    int row;
    int col;
    int last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int img [N][N];
  int n_chk = 0;
  int n_err = 0;
  bit mon_en = 1'b1;
  int win_cnt = 0;
  int last_cnt = 0;
  int first_t[9], last_t[9];
  int first_rc[2], last_rc[2];
  int first_acc, last_acc;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference windows straight from the image array, zero outside it.
  task automatic push_frame();
    exp_t e;
    int lo = PAD ? 0 : 1;
    int hi = PAD ? N - 1 : N - 2;
    for (int r = lo; r <= hi; r++) begin
      for (int c = lo; c <= hi; c++) begin
        for (int dr = 0; dr < 3; dr++) begin
          for (int dc = 0; dc < 3; dc++) begin
            int rr = r - 1 + dr;
            int cc = c - 1 + dc;
            e.t[dr*3+dc] = (rr >= 0 && rr < N && cc >= 0 && cc < N) ? img[rr][cc] : 0;
          end
        end
        e.row  = r;
        e.col  = c;
        e.last = (r == hi && c == hi) ? 1 : 0;
        sb.push_back(e);
      end
    end
  endtask

  task automatic send_frame(input int npix);
    for (int i = 0; i < npix; i++) begin
      int waited = 0;
      bit done = 1'b0;
      in_valid = 1'b1;
      in_data  = 9'(img[(i / N) % N][i % N]);
      while (!done) begin
        @(negedge clk);
        if (in_ready) begin
          done = 1'b1;
          if (i == 0) first_acc = cyc;
          last_acc = cyc;
        end else begin
          waited++;
        end
        @(posedge clk);
        #1;
        if (!done && waited > 50) begin
          chk("in_ready timeout", 0, 1);
          done = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("windows outstanding", sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic stall_check();
    int n = 0;
    int snap[9];
    while (win_cnt < 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 win_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!win_valid && n < 50);
    chk("stall window present", int'(win_valid), 1);
    for (int k = 0; k < 9; k++) snap[k] = int'(w[k]);
    repeat (5) begin
      @(negedge clk);
      chk("stall win_valid", int'(win_valid), 1);
      chk("stall in_ready", int'(in_ready), 0);
      for (int k = 0; k < 9; k++) chk($sformatf("stall hold W%0d", k + 1), int'(w[k]), snap[k]);
    end
    @(posedge clk);
    #1 win_ready = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      win_cnt = 0;
    end else if (mon_en && win_valid && win_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected window", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        for (int k = 0; k < 9; k++) chk($sformatf("W%0d @(%0d,%0d)", k + 1, mon_e.row, mon_e.col), int'(w[k]), mon_e.t[k]);
        chk("win_row", int'(win_row), mon_e.row);
        chk("win_col", int'(win_col), mon_e.col);
        chk("win_last", int'(win_last), mon_e.last);
      end
      if (win_cnt == 0) begin
        for (int k = 0; k < 9; k++) first_t[k] = int'(w[k]);
        first_rc[0] = int'(win_row);
        first_rc[1] = int'(win_col);
      end
      if (win_last) begin
        for (int k = 0; k < 9; k++) last_t[k] = int'(w[k]);
        last_rc[0] = int'(win_row);
        last_rc[1] = int'(win_col);
        last_cnt++;
        win_cnt = 0;
      end else begin
        win_cnt++;
      end
    end
  end

  initial begin
    int hf[9], hl[9];
    int f_rc, l_rc, lc0;
    if (PAD) begin
      hf = '{0, 0, 0, 0, 0, 1, 0, 4, 5};
      hl = '{10, 11, 0, 14, 15, 0, 0, 0, 0};
      f_rc = 0;
      l_rc = 3;
    end else begin
      hf = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
      hl = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
      f_rc = 1;
      l_rc = 2;
    end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        img[r][c] = 4 * r + c;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset win_valid", int'(win_valid), 0);
    chk("reset win_last", int'(win_last), 0);
    chk("reset in_ready", int'(in_ready), 0);
    chk("reset win_row", int'(win_row), 0);
    chk("reset win_col", int'(win_col), 0);
    for (int k = 0; k < 9; k++) chk($sformatf("reset W%0d", k + 1), int'(w[k]), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Continuous frame
    push_frame();
    send_frame(16);
    drain();
    for (int k = 0; k < 9; k++) chk($sformatf("first W%0d", k + 1), first_t[k], hf[k]);
    chk("first row", first_rc[0], f_rc);
    chk("first col", first_rc[1], f_rc);
    for (int k = 0; k < 9; k++) chk($sformatf("last W%0d", k + 1), last_t[k], hl[k]);
    chk("last row", last_rc[0], l_rc);
    chk("last col", last_rc[1], l_rc);

    // Downstream stall mid-frame
    push_frame();
    fork
      send_frame(16);
      stall_check();
    join
    drain();

    // Most negative pixel passes untouched
    img[1][1] = -256;
    push_frame();
    send_frame(16);
    drain();
    chk("neg pixel in first window", first_t[PAD ? 8 : 4], -256);
    img[1][1] = 5;

    // Reset in the middle of a frame
    mon_en = 1'b0;
    send_frame(7);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid reset win_valid", int'(win_valid), 0);
    chk("mid reset in_ready", int'(in_ready), 0);
    chk("mid reset win_last", int'(win_last), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    push_frame();
    send_frame(16);
    drain();
    for (int k = 0; k < 9; k++) chk($sformatf("post-reset first W%0d", k + 1), first_t[k], hf[k]);

    // Two frames back to back
    lc0 = last_cnt;
    push_frame();
    push_frame();
    send_frame(32);
    drain();
    chk("back-to-back accept span", last_acc - first_acc, PAD ? 57 : 31);
    chk("win_last per two frames", last_cnt - lc0, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
